// File: rtl/wb_commit_if.sv
// Result, load-issue, operand-query and register-file write signals of the writeback commit unit.
// The master modport is the EXU/LSU/decode side; the slave modport is wb_commit.
interface wb_commit_if #(
    parameter int unsigned XLEN = 64
) ();
    logic            alu_valid;
    logic            alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;

    logic            lsu_valid;
    logic            lsu_ready;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;

    logic            ld_issue_valid;
    logic [4:0]      ld_issue_rd;

    logic [4:0]      query_rs1;
    logic [4:0]      query_rs2;
    logic            rs1_busy;
    logic            rs2_busy;

    logic            register_write_enable;
    logic [4:0]      register_write_addr;
    logic [XLEN-1:0] register_write_data;
    logic [31:0]     retire_count;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output ld_issue_valid, ld_issue_rd,
        output query_rs1, query_rs2,
        input  alu_ready, lsu_ready, rs1_busy, rs2_busy,
        input  register_write_enable, register_write_addr, register_write_data, retire_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  ld_issue_valid, ld_issue_rd,
        input  query_rs1, query_rs2,
        output alu_ready, lsu_ready, rs1_busy, rs2_busy,
        output register_write_enable, register_write_addr, register_write_data, retire_count
    );
endinterface

// File: rtl/wb_commit.sv
// Writeback commit: LSU-priority arbitration of ALU and load results into one registered
// register-file write per cycle, plus a load scoreboard for decode operand stalls.
module wb_commit #(
    parameter int unsigned XLEN = 64
) (
    input logic       clk,
    input logic       rst,
    wb_commit_if.slave bus
);
    localparam int unsigned RW   = 5;
    localparam int unsigned NREG = 32;
    localparam int unsigned CW   = 32;

    logic            lsu_ready_c;
    logic            alu_ready_c;
    logic            lsu_xfer_c;
    logic            alu_xfer_c;

    logic            we_q,     we_d;
    logic [RW-1:0]   addr_q,   addr_d;
    logic [XLEN-1:0] data_q,   data_d;
    logic [CW-1:0]   retire_q, retire_d;
    logic [NREG-1:0] busy_q,   busy_d;

    logic            rs1_busy_c;
    logic            rs2_busy_c;

    // Handshake: the load path always wins, so at most one transfer per cycle.
    always_comb begin
        lsu_ready_c = !rst;
        alu_ready_c = !rst && !bus.lsu_valid;
        lsu_xfer_c  = bus.lsu_valid && lsu_ready_c;
        alu_xfer_c  = bus.alu_valid && alu_ready_c;
    end

    // Next write-register, counter and scoreboard state.
    always_comb begin
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        retire_d = retire_q;
        busy_d   = busy_q;

        if (lsu_xfer_c) begin
            we_d              = (bus.lsu_rd != RW'(0));
            addr_d            = bus.lsu_rd;
            data_d            = bus.lsu_data;
            retire_d          = retire_q + CW'(1);
            busy_d[bus.lsu_rd] = 1'b0;
        end else if (alu_xfer_c) begin
            we_d     = (bus.alu_rd != RW'(0));
            addr_d   = bus.alu_rd;
            data_d   = bus.alu_data;
            retire_d = retire_q + CW'(1);
        end

        // Applied after the clear so a same-cycle issue to the same rd leaves it busy.
        if (bus.ld_issue_valid && (bus.ld_issue_rd != RW'(0))) begin
            busy_d[bus.ld_issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            retire_q <= '0;
            busy_q   <= '0;
        end else begin
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            retire_q <= retire_d;
            busy_q   <= busy_d;
        end
    end

    // An operand stays busy while its committed value still sits in the write register.
    always_comb begin
        rs1_busy_c = (bus.query_rs1 != RW'(0)) &&
                     (busy_q[bus.query_rs1] || (we_q && (addr_q == bus.query_rs1)));
        rs2_busy_c = (bus.query_rs2 != RW'(0)) &&
                     (busy_q[bus.query_rs2] || (we_q && (addr_q == bus.query_rs2)));
    end

    assign bus.lsu_ready             = lsu_ready_c;
    assign bus.alu_ready             = alu_ready_c;
    assign bus.rs1_busy              = rs1_busy_c;
    assign bus.rs2_busy              = rs2_busy_c;
    assign bus.register_write_enable = we_q;
    assign bus.register_write_addr   = addr_q;
    assign bus.register_write_data   = data_q;
    assign bus.retire_count          = retire_q;
endmodule

// File: tb/tb_wb_commit.sv
// Directed-vector bench for wb_commit; each task drives one scenario and checks inline.
module tb_wb_commit;
    localparam int unsigned XLEN = 64;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    wb_commit_if #(.XLEN(XLEN)) bus ();

    wb_commit #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; registered outputs are stable 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid      = 1'b0;
        bus.lsu_valid      = 1'b0;
        bus.ld_issue_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 64'h11;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd2; bus.lsu_data = 64'h22;
        bus.ld_issue_valid = 1'b0; bus.ld_issue_rd = 5'd0;
        bus.query_rs1 = 5'd1; bus.query_rs2 = 5'd2;
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++;
            if (bus.alu_ready !== 1'b0) begin
                errors++; $display("FAIL reset_alu_ready: got %b expected 0", bus.alu_ready);
            end
            checks++;
            if (bus.lsu_ready !== 1'b0) begin
                errors++; $display("FAIL reset_lsu_ready: got %b expected 0", bus.lsu_ready);
            end
        end
        idle();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.register_write_enable !== 1'b0) begin
            errors++; $display("FAIL reset_we: got %b expected 0", bus.register_write_enable);
        end
        checks++;
        if (bus.register_write_addr !== 5'd0) begin
            errors++; $display("FAIL reset_addr: got %0d expected 0", bus.register_write_addr);
        end
        checks++;
        if (bus.register_write_data !== 64'd0) begin
            errors++; $display("FAIL reset_data: got %h expected 0", bus.register_write_data);
        end
        checks++;
        if (bus.retire_count !== 32'd0) begin
            errors++; $display("FAIL reset_retire: got %0d expected 0", bus.retire_count);
        end
        checks++;
        if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b%b expected 00", bus.rs1_busy, bus.rs2_busy);
        end
    endtask

    task automatic test_single_alu();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 64'h1234;
        #1;
        checks++;
        if (bus.alu_ready !== 1'b1) begin
            errors++; $display("FAIL alu_ready: got %b expected 1", bus.alu_ready);
        end
        cyc();
        idle();
        checks++;
        if (bus.register_write_enable !== 1'b1 || bus.register_write_addr !== 5'd5 ||
            bus.register_write_data !== 64'h1234) begin
            errors++; $display("FAIL alu_write: got we=%b addr=%0d data=%h expected we=1 addr=5 data=1234",
                               bus.register_write_enable, bus.register_write_addr, bus.register_write_data);
        end
        cyc();
        checks++;
        if (bus.register_write_enable !== 1'b0 || bus.register_write_addr !== 5'd5 ||
            bus.retire_count !== 32'd1) begin
            errors++; $display("FAIL alu_after: got we=%b addr=%0d count=%0d expected we=0 addr=5 count=1",
                               bus.register_write_enable, bus.register_write_addr, bus.retire_count);
        end
    endtask

    task automatic test_collision();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 64'hA;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_data = 64'hB;
        #1;
        checks++;
        if (bus.alu_ready !== 1'b0 || bus.lsu_ready !== 1'b1) begin
            errors++; $display("FAIL coll_ready: got alu=%b lsu=%b expected alu=0 lsu=1",
                               bus.alu_ready, bus.lsu_ready);
        end
        cyc();
        bus.lsu_valid = 1'b0;
        checks++;
        if (bus.register_write_enable !== 1'b1 || bus.register_write_addr !== 5'd4 ||
            bus.register_write_data !== 64'hB) begin
            errors++; $display("FAIL coll_lsu_first: got we=%b addr=%0d data=%h expected we=1 addr=4 data=b",
                               bus.register_write_enable, bus.register_write_addr, bus.register_write_data);
        end
        cyc();
        bus.alu_valid = 1'b0;
        checks++;
        if (bus.register_write_enable !== 1'b1 || bus.register_write_addr !== 5'd3 ||
            bus.register_write_data !== 64'hA || bus.retire_count !== 32'd3) begin
            errors++; $display("FAIL coll_alu_second: got we=%b addr=%0d data=%h count=%0d expected we=1 addr=3 data=a count=3",
                               bus.register_write_enable, bus.register_write_addr, bus.register_write_data, bus.retire_count);
        end
        cyc();
        checks++;
        if (bus.register_write_enable !== 1'b0) begin
            errors++; $display("FAIL coll_idle: got we=%b expected 0", bus.register_write_enable);
        end
    endtask

    task automatic test_scoreboard();
        bus.query_rs1 = 5'd7; bus.query_rs2 = 5'd0;
        bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'd7;
        #1;
        checks++;
        if (bus.rs1_busy !== 1'b0) begin
            errors++; $display("FAIL sb_before_issue: got %b expected 0", bus.rs1_busy);
        end
        cyc();
        bus.ld_issue_valid = 1'b0;
        checks++;
        if (bus.rs1_busy !== 1'b1 || bus.rs2_busy !== 1'b0) begin
            errors++; $display("FAIL sb_issued: got rs1=%b rs2=%b expected rs1=1 rs2=0", bus.rs1_busy, bus.rs2_busy);
        end
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 64'h77;
        cyc();
        bus.lsu_valid = 1'b0;
        checks++;
        if (bus.rs1_busy !== 1'b1 || bus.register_write_addr !== 5'd7) begin
            errors++; $display("FAIL sb_in_write_reg: got busy=%b addr=%0d expected busy=1 addr=7",
                               bus.rs1_busy, bus.register_write_addr);
        end
        cyc();
        checks++;
        if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin
            errors++; $display("FAIL sb_cleared: got rs1=%b rs2=%b expected 00", bus.rs1_busy, bus.rs2_busy);
        end
    endtask

    task automatic test_set_clear();
        bus.query_rs1 = 5'd9;
        bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'd9;
        cyc();
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd9; bus.lsu_data = 64'h99;
        cyc();
        idle();
        cyc();
        checks++;
        if (bus.register_write_enable !== 1'b0 || bus.rs1_busy !== 1'b1) begin
            errors++; $display("FAIL setclr_set_wins: got we=%b busy=%b expected we=0 busy=1",
                               bus.register_write_enable, bus.rs1_busy);
        end
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd9; bus.lsu_data = 64'h98;
        cyc();
        bus.lsu_valid = 1'b0;
        cyc();
        checks++;
        if (bus.rs1_busy !== 1'b0) begin
            errors++; $display("FAIL setclr_second_clear: got %b expected 0", bus.rs1_busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  rds [4];
        logic [63:0] dat [4];
        logic [31:0] base;
        rds = '{5'd1, 5'd2, 5'd30, 5'd31};
        dat = '{64'hDEAD_0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h5A5A};
        base = bus.retire_count;
        for (int i = 0; i < 4; i++) begin
            bus.alu_valid = 1'b1; bus.alu_rd = rds[i]; bus.alu_data = dat[i];
            cyc();
            checks++;
            if (bus.register_write_enable !== 1'b1 || bus.register_write_addr !== rds[i] ||
                bus.register_write_data !== dat[i] || bus.retire_count !== base + 32'(i + 1)) begin
                errors++; $display("FAIL b2b_%0d: got we=%b addr=%0d data=%h count=%0d expected we=1 addr=%0d data=%h count=%0d",
                                   i, bus.register_write_enable, bus.register_write_addr, bus.register_write_data,
                                   bus.retire_count, rds[i], dat[i], base + 32'(i + 1));
            end
        end
        idle();
        cyc();
    endtask

    task automatic test_rd0_wrap();
        logic [31:0] base;
        base = bus.retire_count;
        bus.query_rs1 = 5'd0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 64'hFF;
        cyc();
        bus.alu_valid = 1'b0;
        checks++;
        if (bus.register_write_enable !== 1'b0 || bus.register_write_addr !== 5'd0 ||
            bus.retire_count !== base + 32'd1 || bus.rs1_busy !== 1'b0) begin
            errors++; $display("FAIL rd0: got we=%b addr=%0d count=%0d busy=%b expected we=0 addr=0 count=%0d busy=0",
                               bus.register_write_enable, bus.register_write_addr, bus.retire_count,
                               bus.rs1_busy, base + 32'd1);
        end
        force dut.retire_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_q;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 64'h2;
        cyc();
        bus.alu_valid = 1'b0;
        checks++;
        if (bus.retire_count !== 32'd0 || bus.register_write_enable !== 1'b1) begin
            errors++; $display("FAIL wrap: got count=%h we=%b expected count=0 we=1",
                               bus.retire_count, bus.register_write_enable);
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        bus.query_rs1 = 5'd12; bus.query_rs2 = 5'd6;
        bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'd12;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd6; bus.alu_data = 64'h66;
        cyc();
        idle();
        checks++;
        if (bus.rs1_busy !== 1'b1 || bus.rs2_busy !== 1'b1 || bus.register_write_enable !== 1'b1) begin
            errors++; $display("FAIL mid_pre: got rs1=%b rs2=%b we=%b expected 1 1 1",
                               bus.rs1_busy, bus.rs2_busy, bus.register_write_enable);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if (bus.register_write_enable !== 1'b0 || bus.retire_count !== 32'd0 ||
            bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin
            errors++; $display("FAIL mid_reset: got we=%b count=%0d rs1=%b rs2=%b expected 0 0 0 0",
                               bus.register_write_enable, bus.retire_count, bus.rs1_busy, bus.rs2_busy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_alu();
        test_collision();
        test_scoreboard();
        test_set_clear();
        test_back_to_back();
        test_rd0_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_commit.md
# wb_commit

Writeback commit unit; drives the single register-file write port. Arbitrates results from the single-cycle ALU path and the multi-cycle load path into one registered write per cycle. Keeps a load scoreboard so decode can stall on operands whose load has not yet written back. Sits between EXU/LSU and the register file.

## Interface
- XLEN, 64, data width of results and register-file write data
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- alu_valid  in  1  ALU result available this cycle
- alu_ready  out  1  ALU result accepted this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- lsu_valid  in  1  load result available this cycle
- lsu_ready  out  1  load result accepted this cycle
- lsu_rd  in  5  load destination register
- lsu_data  in  XLEN  load result
- ld_issue_valid  in  1  a load is being issued this cycle
- ld_issue_rd  in  5  destination of the issued load
- query_rs1, query_rs2  in  5 each  decode operand addresses
- rs1_busy, rs2_busy  out  1 each  operand not yet readable from the register file
- register_write_enable  out  1  register-file write enable, registered
- register_write_addr  out  5  register-file write address, registered
- register_write_data  out  XLEN  register-file write data, registered
- retire_count  out  32  number of committed results since reset

## Operation
- Transfer on a port = valid && ready in the same cycle.
- lsu_ready = !rst. alu_ready = !rst && !lsu_valid. LSU always has priority; at most one transfer per cycle.
- On a transfer from source S: at the clock edge, register_write_enable <= (S_rd != 0), register_write_addr <= S_rd, register_write_data <= S_data, retire_count += 1.
- No transfer: register_write_enable <= 0; addr and data hold their previous values.
- rd = 0: the handshake completes and retire_count increments, but register_write_enable stays 0.
- retire_count wraps from 0xFFFFFFFF to 0.
- Scoreboard busy[31:1]; busy[0] is constant 0.
  - Set: ld_issue_valid with ld_issue_rd != 0 sets busy[ld_issue_rd].
  - Clear: an LSU transfer clears busy[lsu_rd].
  - Same rd set and cleared in one cycle: set wins, bit ends at 1.
  - Issuing a load to an already-busy rd leaves the bit at 1. The issuer guarantees at most one outstanding load per rd; a violation is undefined.
- rsN_busy = (query_rsN != 0) && (busy[query_rsN] || (register_write_enable && register_write_addr == query_rsN)). This is combinational and covers the one cycle in which a committed value is still in the write register.
- ALU results are never scoreboarded; ALU-to-ALU hazards are the forwarding logic's responsibility.

## Timing
- Reset values:
  - register_write_enable = 0, register_write_addr = 0, register_write_data = 0
  - retire_count = 0; scoreboard all 0
  - alu_ready = 0 and lsu_ready = 0 while rst is high; rs1_busy = rs2_busy = 0 in the cycle after reset
- Latency: a transfer in cycle N gives register_write_enable high in cycle N+1. The register file captures the write at the end of N+1, so the value is readable in N+2.
- rsN_busy falls in cycle N+2 for a load that transfers in cycle N.
- Throughput: one commit per cycle, with no bubbles between back-to-back transfers.
- Reset mid-operation: an in-flight registered write is dropped (enable cleared at the reset edge), pending loads are forgotten, and the counter is zeroed.
- ALU stall: alu_valid must hold alu_rd and alu_data stable until alu_ready is high.

## Test plan
- Reset: hold rst high for 2 cycles with both valids high -> both readys are 0; after release, all outputs are 0 and retire_count = 0.
- Single ALU result: alu_valid=1, rd=5, data=0x1234 in cycle N -> in N+1, enable=1, addr=5, data=0x1234; in N+2, enable=0 and retire_count = 1.
- Collision: alu (rd=3, 0xA) and lsu (rd=4, 0xB) both valid -> LSU commits first with alu_ready=0. ALU held valid commits the next cycle. Two consecutive write cycles, retire_count = 2.
- Scoreboard: issue load rd=7, query_rs1=7 -> rs1_busy=1 from the next cycle. LSU transfer rd=7 in cycle N -> busy still 1 in N+1 (write register), 0 in N+2. query_rs2=0 is always 0.
- Set/clear same cycle: LSU transfer rd=9 while ld_issue rd=9 -> busy[9] stays 1. A second LSU transfer rd=9 clears it.
- rd=0 and wrap: ALU transfer rd=0 -> enable stays 0, count increments. Force retire_count to 0xFFFFFFFF and commit -> count = 0.
